key_expansion_block: RTL

// Iterative AES-128 key schedule; sits directly upstream of add_round_key_block and drives its seed_key/seed_key_vld inputs.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_sbox.sv | 12 +
 rtl/key_expansion_block.sv | 97 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: round count, round constants, the forward
// S-box table and the key-schedule FSM state encoding.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } key_state_e;

  // Row-major forward S-box. Element 0 sits in the leftmost (most significant) position.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  // Entry i produces round key i+1. Index 10 and above are never used.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd0: r = 8'h01;
      4'd1: r = 8'h02;
      4'd2: r = 8'h04;
      4'd3: r = 8'h08;
      4'd4: r = 8'h10;
      4'd5: r = 8'h20;
      4'd6: r = 8'h40;
      4'd7: r = 8'h80;
      4'd8: r = 8'h1b;
      4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES forward S-box; shared by the key schedule and the
// sub_bytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  assign subst = sbox(data);

endmodule

// File: rtl/key_expansion_block.sv
// Iterative AES-128 key schedule: latches one cipher key, then emits round keys
// 0..NUM_ROUNDS in order under a valid/ready handshake, one per cycle at full rate.
module key_expansion_block
  import aes_pkg::*;
#(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic             MainClock,
  input  logic             MainReset,
  input  logic [KEY_W-1:0] seed_key,
  input  logic             seed_key_vld,
  output logic             seed_key_rdy,
  output logic [KEY_W-1:0] round_key,
  output logic             round_key_vld,
  input  logic             round_key_rdy,
  output logic [3:0]       round_idx,
  output logic             round_key_last
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  key_state_e       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       idx_q, idx_d;

  logic [31:0]      w0, w1, w2, w3, rot_w3, sub_w3, t;
  logic [31:0]      n0, n1, n2, n3;
  logic [KEY_W-1:0] next_key;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data  (rot_w3[8*b +: 8]),
      .subst (sub_w3[8*b +: 8])
    );
  end

  // Expansion depends only on the held key and index, never on the ports.
  assign t  = sub_w3 ^ {rcon(idx_q), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // NOTE: every next-state variable is defaulted to its current value first, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (seed_key_vld) begin
          key_d   = seed_key;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (round_key_rdy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block; all state
  // uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge MainClock) begin
    if (MainReset) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  assign seed_key_rdy   = (state_q == IDLE);
  assign round_key_vld  = (state_q == EMIT);
  assign round_key      = key_q;
  assign round_idx      = idx_q;
  assign round_key_last = (state_q == EMIT) && (idx_q == LAST_IDX);

endmodule
